axi_lsu_master: RTL
===================

Name: axi_lsu_master

Overview:
- Load/store bridge between the scoreboard core's memory-access stage and the AXI4 data RAM.
- Converts one scalar load/store request (byte/half/word) into a single-beat AXI4 read or write.
- Performs lane alignment, write-strobe generation and load sign/zero extension, then returns one response per request.
- Single outstanding transaction; sits directly upstream of the AXI4 RAM slave.

Parameters:
ADDR_WIDTH, 16, byte address width; matches slave address bus
ID_WIDTH, 12, AXI ID width; request tag width
(data width fixed at 32 bits, STRB 4)

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
req_valid / req_ready  input / output  1 / 1  request handshake
req_we  input  1  1=store, 0=load
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data, right-justified
req_size  input  2  0=byte, 1=half, 2=word, 3 treated as word
req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
req_id  input  ID_WIDTH  tag; driven on AXI ID, returned on rsp_id
rsp_valid / rsp_ready  output / input  1 / 1  response handshake
rsp_rdata  output  32  extended load data; 0 for stores
rsp_id  output  ID_WIDTH  latched req_id
rsp_err  output  1  1 on SLVERR/DECERR (or misalign trap)
m_axi_awid, awaddr, awlen(8), awsize(3), awburst(2), awlock, awcache(4), awprot(3), awvalid  output; awready input
m_axi_wdata(32), wstrb(4), wlast, wvalid  output; wready input
m_axi_bid(ID_WIDTH), bresp(2), bvalid  input; bready output
m_axi_arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  output; arready input
m_axi_rid, rdata(32), rresp(2), rlast, rvalid  input; rready output

Behaviour:
- Constants: awlen/arlen=0, burst=2'b01 INCR, lock=0, cache=4'b0011, prot=3'b000, wlast=1, size=req_size (3→2).
- All handshake outputs registered. Reset: req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready = 0; rsp_rdata = 0, rsp_err = 0; state=IDLE. req_ready rises the cycle after rst deasserts.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RSP.
- IDLE: req_ready=1. On accept (req_valid&&req_ready), latch all fields, drop req_ready. Load → RD_ADDR; store → WR_ADDR.
- RD_ADDR: arvalid=1, araddr/arid stable until arready; then RD_DATA with rready=1.
- RD_DATA: on rvalid, extract and go to RSP.
  - byte = rdata[8*a[1:0]+:8]; half = rdata[16*a[1]+:16]; word = rdata.
  - Extend per req_unsigned. rsp_err=rresp[1].
- WR_ADDR: awvalid and wvalid assert in the same cycle; each deasserts independently on its own handshake.
  - Payload held stable while valid && !ready.
  - When both handshakes are complete (either order or same cycle), go to WR_RESP with bready=1.
- Store lanes:
  - wdata: byte replicated ×4, half ×2, word as-is.
  - wstrb: byte 4'b0001<<a[1:0]; half 4'b0011<<(2*a[1]); word 4'b1111.
- WR_RESP: on bvalid, rsp_err=bresp[1], rsp_rdata=0, go to RSP.
- RSP: rsp_valid=1 with data/id/err held until rsp_ready. Then IDLE; req_ready returns next cycle. No new request is accepted while rsp_valid=1.
- Latency: rsp_valid no earlier than 3 cycles after accept; with the team AXI RAM and no backpressure, loads take 4 cycles and stores 4 cycles.
- rid/bid are not checked (single outstanding). rlast is ignored.
- Misalignment (macro off): address passes unchanged. Half at a[0]=1 uses the a[1] lane; word ignores a[1:0].
- rst mid-transaction: all valids/readies drop next edge, state IDLE, outstanding AXI response discarded. The slave must be reset in the same cycle.

Optional Feature:
AXI_LSU_MISALIGN_TRAP_EN
- Defined: a half request with a[0]=1 or a word request with a[1:0]!=0 generates no AXI traffic. The block goes IDLE→RSP directly, asserting rsp_valid the cycle after accept with rsp_err=1 and rsp_rdata=0.
- Undefined: no check; behaviour as above.

Test Plan:
- Store word 0xDEADBEEF @0x0010 → awaddr 0x0010, awsize 2, wstrb 4'b1111, rsp_err 0; load word @0x0010 → rsp_rdata 0xDEADBEEF, rsp_id echoes req_id.
- Store byte 0xA5 @0x0013 → wdata 0xA5A5A5A5, wstrb 4'b1000; signed byte load @0x0013 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Word @0x0010 = 0x80017FFF; signed half load @0x0012 → 0xFFFF8001; unsigned half @0x0010 → 0x00007FFF.
- Store with awready held low 5 cycles and wready=1 → wvalid high 1 cycle only, awvalid/awaddr stable 6 cycles; rsp_ready low 3 cycles → rsp_valid/rsp_err held, no new req_ready.
- Slave returns bresp=2'b10 → rsp_err=1. rst asserted while in RD_DATA → arvalid/rready/rsp_valid 0 next cycle, req_ready 1 after release.
- Word load @0x0011: with AXI_LSU_MISALIGN_TRAP_EN → no arvalid, rsp_valid next cycle with rsp_err=1; without → araddr 0x0011, normal completion.

Source files
------------

// File: rtl/axi_lsu_master.sv
// Scalar load/store to single-beat AXI4 bridge with lane alignment, strobes and load extension.
// Optional misalignment trap: define AXI_LSU_MISALIGN_TRAP_EN.
module axi_lsu_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic                  rsp_err,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RSP} state_t;

    state_t                state, state_n;
    logic                  req_ready_n, rsp_valid_n, rsp_err_n;
    logic                  awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [31:0]           rsp_rdata_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [31:0]           wdata_q, lane_wdata, ld_ext;
    logic [3:0]            strb_q, lane_strb;
    logic [1:0]            size_eff;
    logic [7:0]            ld_b;
    logic [15:0]           ld_h;
    logic                  accept, trap;
    logic                  unused_axi;

    // rid/bid/rlast carry no information with a single transaction in flight
    assign unused_axi = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_rresp[0], m_axi_bresp[0]};

    assign accept   = req_valid && req_ready;
    assign size_eff = (req_size == 2'd3) ? 2'd2 : req_size;

`ifdef AXI_LSU_MISALIGN_TRAP_EN
    assign trap = ((size_eff == 2'd1) && req_addr[0]) ||
                  ((size_eff == 2'd2) && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = {1'b0, size_q};
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = {1'b0, size_q};
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign rsp_id        = id_q;

    always_comb begin
        lane_wdata = req_wdata;
        lane_strb  = 4'b1111;
        case (size_eff)
            2'd0: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_strb  = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_strb  = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_b   = m_axi_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_h   = m_axi_rdata[{addr_q[1], 4'b0000} +: 16];
        ld_ext = m_axi_rdata;
        case (size_q)
            2'd0:    ld_ext = {{24{!uns_q && ld_b[7]}}, ld_b};
            2'd1:    ld_ext = {{16{!uns_q && ld_h[15]}}, ld_h};
            default: ;
        endcase
    end

    always_comb begin
        state_n     = state;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
        awvalid_n   = m_axi_awvalid;
        wvalid_n    = m_axi_wvalid;
        bready_n    = m_axi_bready;
        arvalid_n   = m_axi_arvalid;
        rready_n    = m_axi_rready;
        case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (accept) begin
                    req_ready_n = 1'b0;
                    if (trap) begin
                        state_n     = RSP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_rdata_n = 32'd0;
                    end else if (req_we) begin
                        state_n   = WR_ADDR;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end
            end
            RD_ADDR: if (m_axi_arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                state_n   = RD_DATA;
            end
            RD_DATA: if (m_axi_rvalid) begin
                rready_n    = 1'b0;
                rsp_rdata_n = ld_ext;
                rsp_err_n   = m_axi_rresp[1];
                rsp_valid_n = 1'b1;
                state_n     = RSP;
            end
            WR_ADDR: begin
                // each channel retires on its own handshake; move on once both are done
                if (m_axi_awready) awvalid_n = 1'b0;
                if (m_axi_wready)  wvalid_n  = 1'b0;
                if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                    bready_n = 1'b1;
                    state_n  = WR_RESP;
                end
            end
            WR_RESP: if (m_axi_bvalid) begin
                bready_n    = 1'b0;
                rsp_rdata_n = 32'd0;
                rsp_err_n   = m_axi_bresp[1];
                rsp_valid_n = 1'b1;
                state_n     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_n = 1'b0;
                req_ready_n = 1'b1;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_err       <= 1'b0;
            rsp_rdata     <= 32'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            addr_q        <= '0;
            size_q        <= 2'd0;
            uns_q         <= 1'b0;
            id_q          <= '0;
            wdata_q       <= 32'd0;
            strb_q        <= 4'd0;
        end else begin
            state         <= state_n;
            req_ready     <= req_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_err       <= rsp_err_n;
            rsp_rdata     <= rsp_rdata_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= size_eff;
                uns_q   <= req_unsigned;
                id_q    <= req_id;
                wdata_q <= lane_wdata;
                strb_q  <= lane_strb;
            end
        end
    end
endmodule
